// File: rtl/ifetch_prefetch_buffer_pkg.sv
// ifetch_pkg: shared types for the instruction prefetch buffer.
// Holds XLEN/ILEN, FIFO entry struct, fetch FSM encoding, DEPTH default.
package ifetch_pkg;

  localparam int XLEN      = 32;
  localparam int ILEN      = 32;
  localparam int DEPTH_DEF = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] data;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1
  } state_t;

  function automatic logic [XLEN-1:0] word_align(
    input logic [XLEN-1:0] a
  );
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_prefetch_buffer_if.sv
// ifetch_prefetch_buffer_if: memory fetch bus, redirect and instr stream.
// master = fetch stage side, slave = memory/core side.
interface ifetch_prefetch_buffer_if;
  import ifetch_pkg::*;

  logic            mem_req_valid;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_req_ready;
  logic            mem_rsp_valid;
  logic [ILEN-1:0] mem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            instr_valid;
  logic            instr_ready;
  logic [ILEN-1:0] instr_data;
  logic [XLEN-1:0] instr_pc;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_data,
    input  redirect_valid, redirect_pc,
    output instr_valid, instr_data, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_data,
    output redirect_valid, redirect_pc,
    input  instr_valid, instr_data, instr_pc,
    output instr_ready
  );

endinterface

// File: rtl/ifetch_prefetch_buffer_fifo.sv
// ifetch_fifo: in-order sync FIFO of {pc,data} entries with flush.
// Ports: clk, rst_n, flush_i, push_i/push_entry_i, pop_i, head_o, empty_o, count_o.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  entry_t        push_entry_i,
  input  logic          pop_i,
  output entry_t        head_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_pop;
  logic          full;

  assign empty_o = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign do_pop  = pop_i && !empty_o;
  // Empty head reads as zero so the stream outputs stay clean.
  assign head_o  = empty_o ? '0 : mem_q[rd_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        wr_q <= wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= rd_q + 1'b1;
      end
      cnt_q <= cnt_q + CW'(push_i) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      mem_q[wr_q] <= push_entry_i;
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(push_i && full && !do_pop && !flush_i)
  );

endmodule

// File: rtl/ifetch_prefetch_buffer.sv
// ifetch_prefetch_buffer: credit-limited sequential fetch, drop-on-redirect, FIFO.
// Ports: clk, rst_n, bus (master); IFETCH_PERF_EN adds perf_starve_cnt/perf_flush_cnt.
module ifetch_prefetch_buffer
  import ifetch_pkg::*;
#(
  parameter int              DEPTH    = DEPTH_DEF,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst_n,
  ifetch_prefetch_buffer_if.master bus
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_starve_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 1;

  state_t          state_q;
  logic            run_q;
  logic [XLEN-1:0] fetch_pc_q;
  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]   out_q;
  logic [CW-1:0]   out_d;
  logic [CW-1:0]   drop_q;
  logic [CW-1:0]   drop_d;
  logic [CW-1:0]   fifo_cnt;
  logic [SW-1:0]   inflight;
  entry_t          head;
  entry_t          push_entry;
  logic            empty;
  logic            redir;
  logic            accept;
  logic            rsp;
  logic            push;
  logic            pop;

  assign redir    = bus.redirect_valid;
  assign rsp      = bus.mem_rsp_valid;
  assign inflight = SW'(fifo_cnt) + SW'(out_q);

  // run_q keeps the request line low through reset.
  assign bus.mem_req_valid = run_q && !redir &&
                             (inflight < SW'(DEPTH));
  assign bus.mem_req_addr  = fetch_pc_q;
  assign accept = bus.mem_req_valid && bus.mem_req_ready;

  // Words returning in DRAIN or in a redirect cycle are stale.
  assign push = rsp && (state_q == FETCH) && !redir;
  assign push_entry.pc   = pc_q;
  assign push_entry.data = bus.mem_rsp_data;

  assign bus.instr_valid = !empty && !redir;
  assign bus.instr_data  = head.data;
  assign bus.instr_pc    = head.pc;
  assign pop = bus.instr_valid && bus.instr_ready;

  assign out_d = out_q + CW'(accept) - CW'(rsp);

  always_comb begin
    drop_d = drop_q;
    if (redir) begin
      drop_d = out_d;
    end else if (rsp && drop_q != '0) begin
      drop_d = drop_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      run_q      <= 1'b0;
      fetch_pc_q <= RESET_PC;
      pc_q       <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
    end else begin
      run_q  <= 1'b1;
      out_q  <= out_d;
      drop_q <= drop_d;
      unique case (state_q)
        FETCH: if (drop_d != '0) state_q <= DRAIN;
        DRAIN: if (drop_d == '0) state_q <= FETCH;
        default: state_q <= FETCH;
      endcase
      if (redir) begin
        fetch_pc_q <= word_align(bus.redirect_pc);
        pc_q       <= word_align(bus.redirect_pc);
      end else begin
        if (accept) fetch_pc_q <= fetch_pc_q + 32'd4;
        if (push)   pc_q       <= pc_q + 32'd4;
      end
    end
  end

  ifetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (redir),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head),
    .empty_o      (empty),
    .count_o      (fifo_cnt)
  );

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_starve_cnt <= '0;
      perf_flush_cnt  <= '0;
    end else begin
      if (bus.instr_ready && !bus.instr_valid &&
          perf_starve_cnt != '1) begin
        perf_starve_cnt <= perf_starve_cnt + 32'd1;
      end
      if (redir && perf_flush_cnt != '1) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_prefetch_buffer.sv
// tb_ifetch_prefetch_buffer: vector table plus redirect/wrap/reset sequences.
// Memory model returns addr ^ 32'h5A5A_C3C3 after a programmable latency.
module tb_ifetch_prefetch_buffer;
  import ifetch_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ifetch_prefetch_buffer_if bus();
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_starve_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  ifetch_prefetch_buffer #(
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef IFETCH_PERF_EN
    ,
    .perf_starve_cnt (perf_starve_cnt),
    .perf_flush_cnt  (perf_flush_cnt)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  typedef struct {
    bit          iready;
    bit          req;
    logic [31:0] addr;
    bit          iv;
    logic [31:0] pc;
  } vec_t;

  req_t        pend[$];
  logic [31:0] acc_log[$];
  vec_t        tv[9];

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  int lat  = 1;
  int nacc = 0;
  int npop = 0;
  bit mready = 0;
  bit iready = 0;
  bit redir  = 0;
  logic [31:0] rpc = '0;
  logic [31:0] exp_pc = '0;
  logic [31:0] first_pc = '0;
  logic        s_req;
  logic [31:0] s_addr;
  logic        s_iv;
  logic [31:0] s_pc;
  logic [31:0] s_data;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.mem_req_ready  = 1'b0;
    bus.mem_rsp_valid  = 1'b0;
    bus.mem_rsp_data   = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.instr_ready    = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("rst_req_valid", {31'b0, bus.mem_req_valid}, 32'h0);
    chk("rst_instr_valid", {31'b0, bus.instr_valid}, 32'h0);
    chk("rst_instr_data", bus.instr_data, 32'h0);
    chk("rst_instr_pc", bus.instr_pc, 32'h0);
    pend.delete();
    acc_log.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0; nacc = 0; npop = 0; exp_pc = 32'h0;
    redir = 0;
  endtask

  task automatic step();
    req_t r;
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = word(pend[0].addr);
      void'(pend.pop_front());
    end
    bus.mem_req_ready  = mready;
    bus.instr_ready    = iready;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    #1;
    s_req  = bus.mem_req_valid;
    s_addr = bus.mem_req_addr;
    s_iv   = bus.instr_valid;
    s_pc   = bus.instr_pc;
    s_data = bus.instr_data;
    if (s_req && mready) begin
      r.addr = s_addr;
      r.due  = cyc + lat;
      pend.push_back(r);
      acc_log.push_back(s_addr);
      nacc++;
    end
    if (s_iv && iready) begin
      if (npop == 0) first_pc = s_pc;
      npop++;
      chk("pop_pc", s_pc, exp_pc);
      chk("pop_data", s_data, word(exp_pc));
      exp_pc = exp_pc + 32'd4;
    end
    if (redir) begin
      chk("redir_req_valid", {31'b0, s_req}, 32'h0);
      chk("redir_instr_valid", {31'b0, s_iv}, 32'h0);
      exp_pc = {rpc[31:2], 2'b00};
      acc_log.delete();
      npop = 0;
    end
    cyc++;
  endtask

  initial begin
    idle_inputs();
    tv[0] = '{1, 1, 32'h00, 0, 32'h0};
    tv[1] = '{1, 1, 32'h04, 0, 32'h0};
    tv[2] = '{1, 1, 32'h08, 1, 32'h0};
    tv[3] = '{1, 1, 32'h0C, 1, 32'h4};
    tv[4] = '{0, 1, 32'h10, 1, 32'h8};
    tv[5] = '{0, 1, 32'h14, 1, 32'h8};
    tv[6] = '{0, 0, 32'h00, 1, 32'h8};
    tv[7] = '{1, 0, 32'h00, 1, 32'h8};
    tv[8] = '{1, 1, 32'h18, 1, 32'hC};

    @(negedge clk);
    do_reset();

    // Table: startup stream, 1-cycle memory, backpressure.
    lat = 1; mready = 1;
    for (int i = 0; i < 9; i++) begin
      iready = tv[i].iready;
      step();
      chk($sformatf("v%0d_req", i), {31'b0, s_req}, {31'b0, tv[i].req});
      if (tv[i].req) chk($sformatf("v%0d_addr", i), s_addr, tv[i].addr);
      chk($sformatf("v%0d_iv", i), {31'b0, s_iv}, {31'b0, tv[i].iv});
      if (tv[i].iv) begin
        chk($sformatf("v%0d_pc", i), s_pc, tv[i].pc);
        chk($sformatf("v%0d_data", i), s_data, word(tv[i].pc));
      end
    end

    // Core stalled: FIFO fills, credits run out, one pop frees one.
    do_reset();
    lat = 1; mready = 1; iready = 0;
    repeat (20) step();
    chk("full_nacc", nacc, 4);
    chk("full_req_valid", {31'b0, s_req}, 32'h0);
    iready = 1;
    step();
    iready = 0;
    repeat (5) step();
    chk("refill_nacc", nacc, 5);
    chk("refill_addr", acc_log[$], 32'h10);

    // Redirect with 3 outstanding, latency 5.
    do_reset();
    lat = 5; mready = 1; iready = 1;
    repeat (3) step();
    mready = 0;
    step();
    chk("pre_redir_nacc", nacc, 3);
    mready = 1; redir = 1; rpc = 32'h0000_1003;
    step();
    redir = 0;
    repeat (25) step();
    chk("r1_first_pc", first_pc, 32'h1000);
    chk("r1_first_req", acc_log[0], 32'h1000);
    chk("r1_delivered", {31'b0, npop > 0}, 32'h1);

    // Redirect coinciding with a response and mem_req_ready.
    do_reset();
    lat = 2; mready = 1; iready = 1;
    repeat (2) step();
    redir = 1; rpc = 32'h0000_2000;
    step();
    redir = 0;
    chk("r2_nacc", nacc, 2);
    repeat (12) step();
    chk("r2_first_pc", first_pc, 32'h2000);
    chk("r2_first_req", acc_log[0], 32'h2000);
    chk("r2_delivered", {31'b0, npop > 0}, 32'h1);

    // Fetch address wrap.
    redir = 1; rpc = 32'hFFFF_FFFC;
    step();
    redir = 0;
    repeat (10) step();
    chk("wrap_req0", acc_log[0], 32'hFFFF_FFFC);
    chk("wrap_req1", acc_log[1], 32'h0000_0000);
    chk("wrap_first_pc", first_pc, 32'hFFFF_FFFC);

    // Reset mid-stream with 2 outstanding and a valid head.
    do_reset();
    lat = 3; mready = 1; iready = 0;
    repeat (5) step();
    @(posedge clk);
    #2;
    chk("mid_iv_before", {31'b0, bus.instr_valid}, 32'h1);
    chk("mid_data_before", bus.instr_data, word(32'h0));
    chk("mid_outstanding", pend.size(), 2);
    do_reset();
    lat = 1; mready = 1; iready = 1;
    repeat (10) step();
    chk("mid_first_req", acc_log[0], 32'h0);
    chk("mid_first_pc", first_pc, 32'h0);
    chk("mid_delivered", {31'b0, npop > 0}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
